// File: rtl/reg_file_sweep.sv
// DEPTH x DATA_W register file: one synchronous write port, two combinational read ports, CLEAR sweep sequencer.
// Reads have zero latency; writes land at the next edge; writes offered while a sweep is running are dropped, never stalled.
module reg_file_sweep #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_acc;

  // A write aimed at a hardwired-zero R0 is treated as never having been accepted.
  assign wr_acc = wr_en && (state_q == IDLE) && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // wr_acc is already low during CLEAR, so forwarding never leaks into a sweep.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if ((ZERO_R0 != 0) && (addr == '0)) begin
      return '0;
    end else if ((BYPASS != 0) && wr_acc && (wr_addr == addr)) begin
      return wr_data;
    end else begin
      return mem_q[addr];
    end
  endfunction

  assign rd_data_1 = read_port(rd_addr_1);
  assign rd_data_2 = read_port(rd_addr_2);
  assign clr_busy  = busy_q;
  assign clr_done  = done_q;

endmodule

// File: tb/tb_reg_file_sweep.sv
// Bench for reg_file_sweep: three parameterisations share one stimulus stream.
// Expected values are queued as stimulus is driven and popped at the sample point.
module tb_reg_file_sweep;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr_1, rd_addr_2;
  logic        clr_req;

  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2, z_rd1, z_rd2;
  logic        a_busy, a_done, b_busy, b_done, z_busy, z_done;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp;

  always #5 clock = ~clock;

  reg_file_sweep #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_R0(0)) u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_data_1(a_rd1), .rd_data_2(a_rd2),
    .clr_req(clr_req), .clr_busy(a_busy), .clr_done(a_done));

  reg_file_sweep #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_R0(0)) u_nobyp (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_data_1(b_rd1), .rd_data_2(b_rd2),
    .clr_req(clr_req), .clr_busy(b_busy), .clr_done(b_done));

  reg_file_sweep #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_R0(1)) u_zero (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .rd_data_1(z_rd1), .rd_data_2(z_rd2),
    .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done));

  // Stimulus helper: entered and left one time unit after a rising edge.
  task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_1 = 4'd3; rd_addr_2 = 4'd15; clr_req = 1'b0;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    @(posedge clock); #1;
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL reset_rd1: got %h expected %h", a_rd1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd2 !== exp) begin errors++; $display("FAIL reset_rd2: got %h expected %h", a_rd2, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_busy} !== exp) begin errors++; $display("FAIL reset_busy: got %h expected %h", a_busy, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_done} !== exp) begin errors++; $display("FAIL reset_done: got %h expected %h", a_done, exp); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_write_read();
    write_reg(4'd3, 16'h1234);
    rd_addr_1 = 4'd3; rd_addr_2 = 4'd3;
    exp_q.push_back(16'h1234); exp_q.push_back(16'h1234); exp_q.push_back(16'h1234);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL wr_rd_port1: got %h expected %h", a_rd1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd2 !== exp) begin errors++; $display("FAIL wr_rd_port2: got %h expected %h", a_rd2, exp); end
    exp = exp_q.pop_front(); checks++;
    if (b_rd1 !== exp) begin errors++; $display("FAIL wr_rd_nobyp: got %h expected %h", b_rd1, exp); end
    @(posedge clock); #1;
  endtask

  task automatic test_bypass();
    write_reg(4'd5, 16'h1111);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    rd_addr_1 = 4'd5; rd_addr_2 = 4'd5;
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF); exp_q.push_back(16'h1111);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL bypass_port1: got %h expected %h", a_rd1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd2 !== exp) begin errors++; $display("FAIL bypass_port2: got %h expected %h", a_rd2, exp); end
    exp = exp_q.pop_front(); checks++;
    if (b_rd1 !== exp) begin errors++; $display("FAIL nobyp_before_edge: got %h expected %h", b_rd1, exp); end
    @(posedge clock); #1;
    wr_en = 1'b0;
    exp_q.push_back(16'hBEEF);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (b_rd1 !== exp) begin errors++; $display("FAIL nobyp_after_edge: got %h expected %h", b_rd1, exp); end
    @(posedge clock); #1;
  endtask

  task automatic test_zero_r0();
    rd_addr_1 = 4'd0; rd_addr_2 = 4'd1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    exp_q.push_back(16'h0000); exp_q.push_back(16'hFFFF);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (z_rd1 !== exp) begin errors++; $display("FAIL r0_no_bypass: got %h expected %h", z_rd1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL r0_plain_bypass: got %h expected %h", a_rd1, exp); end
    @(posedge clock); #1;
    wr_en = 1'b0;
    write_reg(4'd1, 16'h0101);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0101); exp_q.push_back(16'hFFFF);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (z_rd1 !== exp) begin errors++; $display("FAIL r0_reads_zero: got %h expected %h", z_rd1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (z_rd2 !== exp) begin errors++; $display("FAIL r1_write_ok: got %h expected %h", z_rd2, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL r0_plain_stored: got %h expected %h", a_rd1, exp); end
    @(posedge clock); #1;
  endtask

  task automatic test_sweep();
    int bcnt, dcnt;
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'(16'h00A0 + i));
    rd_addr_1 = 4'd4; rd_addr_2 = 4'd2;
    // Write offered alongside clr_req while still IDLE must land.
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0BAD;
    exp_q.push_back(16'h0BAD); exp_q.push_back(16'h00A4); exp_q.push_back(16'h0000);
    exp_q.push_back(16'd16);   exp_q.push_back(16'd1);
    @(posedge clock); #1;
    clr_req = 1'b0; wr_en = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (a_busy) bcnt++;
      if (a_done) dcnt++;
      if (c == 0) begin
        exp = exp_q.pop_front(); checks++;
        if (a_rd2 !== exp) begin errors++; $display("FAIL idle_write_with_clr: got %h expected %h", a_rd2, exp); end
      end
      if (c == 3) begin
        exp = exp_q.pop_front(); checks++;
        if (a_rd1 !== exp) begin errors++; $display("FAIL r4_cycle3: got %h expected %h", a_rd1, exp); end
      end
      if (c == 5) begin
        exp = exp_q.pop_front(); checks++;
        if (a_rd1 !== exp) begin errors++; $display("FAIL r4_cycle5: got %h expected %h", a_rd1, exp); end
      end
    end
    exp = exp_q.pop_front(); checks++;
    if (16'(bcnt) !== exp) begin errors++; $display("FAIL sweep_busy_cycles: got %0d expected %0d", bcnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if (16'(dcnt) !== exp) begin errors++; $display("FAIL sweep_done_pulses: got %0d expected %0d", dcnt, exp); end
    for (int i = 0; i < 16; i++) begin
      rd_addr_1 = 4'(i); rd_addr_2 = 4'(15 - i);
      exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (a_rd1 !== exp) begin errors++; $display("FAIL swept_entry_p1[%0d]: got %h expected %h", i, a_rd1, exp); end
      exp = exp_q.pop_front(); checks++;
      if (a_rd2 !== exp) begin errors++; $display("FAIL swept_entry_p2[%0d]: got %h expected %h", 15 - i, a_rd2, exp); end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_drop_write();
    int bcnt, dcnt;
    rd_addr_1 = 4'd7;
    clr_req = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'd16); exp_q.push_back(16'd1); exp_q.push_back(16'h0000);
    @(posedge clock); #1;
    clr_req = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (a_busy) bcnt++;
      if (a_done) dcnt++;
      if (c == 10) begin
        exp = exp_q.pop_front(); checks++;
        if (a_rd1 !== exp) begin errors++; $display("FAIL no_bypass_in_clear: got %h expected %h", a_rd1, exp); end
        wr_en = 1'b0;
      end
      if (c == 2) clr_req = 1'b1;
      if (c == 8) clr_req = 1'b0;
      if (c == 9) begin wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0777; end
    end
    exp = exp_q.pop_front(); checks++;
    if (16'(bcnt) !== exp) begin errors++; $display("FAIL clr_req_busy_cycles: got %0d expected %0d", bcnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if (16'(dcnt) !== exp) begin errors++; $display("FAIL clr_req_single_done: got %0d expected %0d", dcnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL r7_write_dropped: got %h expected %h", a_rd1, exp); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_abort();
    int bcnt, dcnt;
    write_reg(4'd10, 16'h5555);
    write_reg(4'd2, 16'h2222);
    rd_addr_1 = 4'd10; rd_addr_2 = 4'd2;
    clr_req = 1'b1;
    exp_q.push_back(16'h5555); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'd0);    exp_q.push_back(16'd16);   exp_q.push_back(16'd1);
    @(posedge clock); #1;
    clr_req = 1'b0;
    for (int c = 0; c <= 6; c++) @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL r10_unswept: got %h expected %h", a_rd1, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd2 !== exp) begin errors++; $display("FAIL r2_swept: got %h expected %h", a_rd2, exp); end
    reset = 1'b1;
    #1;
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_busy} !== exp) begin errors++; $display("FAIL abort_busy: got %h expected %h", a_busy, exp); end
    exp = exp_q.pop_front(); checks++;
    if (a_rd1 !== exp) begin errors++; $display("FAIL abort_r10: got %h expected %h", a_rd1, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_done} !== exp) begin errors++; $display("FAIL abort_done: got %h expected %h", a_done, exp); end
    @(posedge clock); #1;
    reset = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (a_done) dcnt++;
    end
    exp = exp_q.pop_front(); checks++;
    if (16'(dcnt) !== exp) begin errors++; $display("FAIL abort_no_done: got %0d expected %0d", dcnt, exp); end
    @(posedge clock); #1;
    clr_req = 1'b1;
    @(posedge clock); #1;
    clr_req = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (a_busy) bcnt++;
      if (a_done) dcnt++;
    end
    exp = exp_q.pop_front(); checks++;
    if (16'(bcnt) !== exp) begin errors++; $display("FAIL resweep_busy: got %0d expected %0d", bcnt, exp); end
    exp = exp_q.pop_front(); checks++;
    if (16'(dcnt) !== exp) begin errors++; $display("FAIL resweep_done: got %0d expected %0d", dcnt, exp); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int  bcnt;
    bit  found;
    clr_req = 1'b1;
    exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd1); exp_q.push_back(16'd0);
    exp_q.push_back(16'd1); exp_q.push_back(16'd16);
    @(posedge clock); #1;
    for (int c = 0; c < 16; c++) @(negedge clock);
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_busy} !== exp) begin errors++; $display("FAIL b2b_gap_busy: got %h expected %h", a_busy, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_done} !== exp) begin errors++; $display("FAIL b2b_gap_done: got %h expected %h", a_done, exp); end
    @(negedge clock);
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_busy} !== exp) begin errors++; $display("FAIL b2b_restart_busy: got %h expected %h", a_busy, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, a_done} !== exp) begin errors++; $display("FAIL b2b_restart_done: got %h expected %h", a_done, exp); end
    clr_req = 1'b0;
    bcnt = 1; found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clock);
      if (a_busy) bcnt++;
      if (a_done) found = 1'b1;
    end
    exp = exp_q.pop_front(); checks++;
    if ({15'd0, found} !== exp) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d (timeout)", found, exp); end
    exp = exp_q.pop_front(); checks++;
    if (16'(bcnt) !== exp) begin errors++; $display("FAIL b2b_second_busy: got %0d expected %0d", bcnt, exp); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_r0();
    test_sweep();
    test_drop_write();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
